serial_rx_sync_ctrl: RTL and testbench

Receive-side controller for the serial link. It runs at clk_32f, one serial bit per clock, and hunts for the COM symbol to establish byte alignment. It qualifies lock after consecutive COMs, then asserts active and delivers aligned data bytes to the parallel side. It also detects loss of lock when COM stops arriving and returns to hunting.

---
 rtl/serial_rx_sync_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_serial_rx_sync_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// serial_rx_sync_ctrl
//
// Receive-side byte aligner for the serial link. One serial bit arrives per
// clk_32f cycle, MSB of each byte first. The block hunts for the COM symbol at
// any bit offset. After LOCK_COUNT consecutive COMs on the same byte grid it
// declares lock (active). It then delivers every aligned byte that is neither
// COM nor IDLE on data_out with a one-cycle valid_out strobe. Lock is dropped
// when MAX_GAP byte slots pass without an aligned COM.
//
// Ports:
//   clk_32f        in   1  bit clock, all state on the rising edge
//   reset          in   1  asynchronous, active-high reset
//   data_in        in   1  serial bit, MSB first
//   data_out       out  8  last delivered data byte (held until next strobe)
//   valid_out      out  1  one-cycle strobe, data_out updated this cycle
//   active         out  1  link locked and delivering (state == ACTIVE)
//   state_out      out  2  FSM state: HUNT=0, LOCKING=1, ACTIVE=2
//   lock_loss_cnt  out  8  saturating count of lock losses and aborted lock
//                          attempts; present only when the macro
//                          SYNC_ERR_CNT_EN is defined
// ---------------------------------------------------------------------------
module serial_rx_sync_ctrl #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  IDLE_SYM   = 8'h7C,
  parameter int unsigned LOCK_COUNT = 32'd4,
  parameter int unsigned MAX_GAP    = 32'd32
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] state_out
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
  // The gap count reaches this value just before the byte that breaks lock.
  localparam logic [7:0] GAP_LAST    = 8'(MAX_GAP - 32'd1);

  state_e     state_r;
  state_e     state_nx_s;
  logic [7:0] sr_r;
  logic [2:0] bit_cnt_r;
  logic [2:0] bit_cnt_nx_s;
  logic [3:0] com_cnt_r;
  logic [3:0] com_cnt_nx_s;
  logic [7:0] gap_cnt_r;
  logic [7:0] gap_cnt_nx_s;
  logic [7:0] data_out_r;
  logic       valid_out_r;
  logic       active_r;

  logic [7:0] w_s;
  logic       byte_ev_s;
  logic       com_hit_s;
  logic       idle_hit_s;
  logic       lock_drop_s;
  logic       deliver_s;

  // The window includes the bit being sampled now, so a byte is seen in the
  // same cycle its last bit arrives.
  assign w_s         = {sr_r[6:0], data_in};
  assign byte_ev_s   = (state_r != ST_HUNT) && (bit_cnt_r == 3'd7);
  assign com_hit_s   = (w_s == COM_SYM);
  assign idle_hit_s  = (w_s == IDLE_SYM);
  // Only an aligned non-COM byte can push the gap over the limit.
  assign lock_drop_s = (state_r == ST_ACTIVE) && byte_ev_s && !com_hit_s &&
                       (gap_cnt_r == GAP_LAST);

  // FSM state register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (com_hit_s) begin
          if (LOCK_COUNT == 32'd1) begin
            state_nx_s = ST_ACTIVE;
          end else begin
            state_nx_s = ST_LOCKING;
          end
        end else begin
          state_nx_s = ST_HUNT;
        end
      end
      ST_LOCKING: begin
        if (byte_ev_s && com_hit_s) begin
          if ((com_cnt_r + 4'd1) == LOCK_TARGET) begin
            state_nx_s = ST_ACTIVE;
          end else begin
            state_nx_s = ST_LOCKING;
          end
        end else if (byte_ev_s) begin
          state_nx_s = ST_HUNT;
        end else begin
          state_nx_s = ST_LOCKING;
        end
      end
      ST_ACTIVE: begin
        if (lock_drop_s) begin
          state_nx_s = ST_HUNT;
        end else begin
          state_nx_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nx_s = ST_HUNT;
      end
    endcase
  end

  // FSM output decode: counter updates and byte delivery
  always_comb begin
    bit_cnt_nx_s = 3'd0;
    com_cnt_nx_s = com_cnt_r;
    gap_cnt_nx_s = gap_cnt_r;
    deliver_s    = 1'b0;
    case (state_r)
      ST_HUNT: begin
        // Restarting the bit counter on the match cycle puts the next byte
        // event exactly eight cycles later.
        bit_cnt_nx_s = 3'd0;
        if (com_hit_s) begin
          com_cnt_nx_s = 4'd1;
          gap_cnt_nx_s = 8'd0;
        end else begin
          com_cnt_nx_s = 4'd0;
        end
      end
      ST_LOCKING: begin
        bit_cnt_nx_s = bit_cnt_r + 3'd1;
        if (byte_ev_s && com_hit_s) begin
          com_cnt_nx_s = com_cnt_r + 4'd1;
          gap_cnt_nx_s = 8'd0;
        end else if (byte_ev_s) begin
          com_cnt_nx_s = 4'd0;
        end else begin
          com_cnt_nx_s = com_cnt_r;
        end
      end
      ST_ACTIVE: begin
        bit_cnt_nx_s = bit_cnt_r + 3'd1;
        if (byte_ev_s && com_hit_s) begin
          gap_cnt_nx_s = 8'd0;
        end else if (lock_drop_s) begin
          // The byte that breaks lock is discarded, not delivered.
          com_cnt_nx_s = 4'd0;
          gap_cnt_nx_s = 8'd0;
        end else if (byte_ev_s) begin
          gap_cnt_nx_s = (gap_cnt_r == 8'hFF) ? 8'hFF : (gap_cnt_r + 8'd1);
          deliver_s    = !idle_hit_s;
        end else begin
          gap_cnt_nx_s = gap_cnt_r;
        end
      end
      default: begin
        bit_cnt_nx_s = 3'd0;
        com_cnt_nx_s = 4'd0;
        gap_cnt_nx_s = 8'd0;
      end
    endcase
  end

  // Shift register, alignment counters and registered outputs
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr_r        <= 8'h00;
      bit_cnt_r   <= 3'd0;
      com_cnt_r   <= 4'd0;
      gap_cnt_r   <= 8'd0;
      data_out_r  <= 8'h00;
      valid_out_r <= 1'b0;
      active_r    <= 1'b0;
    end else begin
      sr_r        <= w_s;
      bit_cnt_r   <= bit_cnt_nx_s;
      com_cnt_r   <= com_cnt_nx_s;
      gap_cnt_r   <= gap_cnt_nx_s;
      valid_out_r <= deliver_s;
      active_r    <= (state_nx_s == ST_ACTIVE);
      if (deliver_s) begin
        data_out_r <= w_s;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign active    = active_r;
  assign state_out = state_r;

`ifdef SYNC_ERR_CNT_EN
  logic [7:0] loss_cnt_r;
  logic       loss_ev_s;

  // Any exit to HUNT counts: gap loss from ACTIVE or an aborted lock attempt.
  assign loss_ev_s = (state_r != ST_HUNT) && (state_nx_s == ST_HUNT);

  // Saturating lock-loss counter
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      loss_cnt_r <= 8'h00;
    end else if (loss_ev_s && (loss_cnt_r != 8'hFF)) begin
      loss_cnt_r <= loss_cnt_r + 8'd1;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign lock_loss_cnt = loss_cnt_r;
`endif

endmodule

// File: tb/tb_serial_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for serial_rx_sync_ctrl (default parameters).
// A byte-grid reference model runs alongside the DUT on every cycle. Table
// vectors, hand-written corner sequences and a randomized byte stream are
// applied on top of it.
// ---------------------------------------------------------------------------
module tb_serial_rx_sync_ctrl;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] IDL    = 8'h7C;
  localparam int         LOCK_N = 4;
  localparam int         GAP_N  = 32;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [1:0] state_out;
`ifdef SYNC_ERR_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_rx_sync_ctrl dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .state_out (state_out)
`ifdef SYNC_ERR_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: byte events are scheduled by absolute cycle number.
  longint     m_cyc;
  longint     m_next_ev;
  logic [7:0] m_hist;
  int         m_mode;   // 0 hunting, 1 locking, 2 locked
  int         m_coms;
  int         m_gap;
  logic [7:0] m_data;
  logic       m_valid;
  int         m_loss;

  typedef struct {
    logic [7:0] byte_in;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_active;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hist    = 8'h00;
    m_mode    = 0;
    m_coms    = 0;
    m_gap     = 0;
    m_data    = 8'h00;
    m_valid   = 1'b0;
    m_loss    = 0;
    m_next_ev = -1;
  endtask

  task automatic model_step(input logic b);
    logic [7:0] win;
    win     = {m_hist[6:0], b};
    m_valid = 1'b0;
    if (m_mode == 0) begin
      if (win == COM) begin
        m_coms    = 1;
        m_next_ev = m_cyc + 8;
        m_gap     = 0;
        m_mode    = (LOCK_N == 1) ? 2 : 1;
      end
    end else if (m_cyc == m_next_ev) begin
      m_next_ev = m_cyc + 8;
      if (m_mode == 1) begin
        if (win == COM) begin
          m_coms++;
          if (m_coms == LOCK_N) begin
            m_mode = 2;
            m_gap  = 0;
          end
        end else begin
          m_mode = 0;
          m_coms = 0;
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        end
      end else begin
        if (win == COM) begin
          m_gap = 0;
        end else if (m_gap == GAP_N - 1) begin
          m_mode = 0;
          m_coms = 0;
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        end else begin
          m_gap = (m_gap < 255) ? m_gap + 1 : 255;
          if (win != IDL) begin
            m_data  = win;
            m_valid = 1'b1;
          end
        end
      end
    end
    m_hist = win;
    m_cyc++;
  endtask

  // One bit time: drive, clock, then compare everything against the model.
  task automatic cycle(input logic b);
    logic [1:0] exp_st;
    data_in = b;
    if (reset) model_reset();
    else model_step(b);
    @(posedge clk_32f);
    #1;
    exp_st = 2'(m_mode);
    check("model_outputs",
          32'({data_out, valid_out, active, state_out}),
          32'({m_data, m_valid, (m_mode == 2), exp_st}));
`ifdef SYNC_ERR_CNT_EN
    check("model_lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) cycle(v[i]);
  endtask

  initial begin
    m_cyc   = 0;
    reset   = 1'b1;
    data_in = 1'b0;
    model_reset();
    repeat (3) cycle(1'b0);
    check("reset_data_out",  32'(data_out),  32'h00);
    check("reset_valid_out", 32'(valid_out), 32'h0);
    check("reset_active",    32'(active),    32'h0);
    check("reset_state_out", 32'(state_out), 32'h0);
    reset = 1'b0;

    // Lock on four aligned COMs, then IDLE / data / data / COM.
    tbl[0] = '{8'hBC, 1'b0, 8'h00, 1'b0, 2'd1};
    tbl[1] = '{8'hBC, 1'b0, 8'h00, 1'b0, 2'd1};
    tbl[2] = '{8'hBC, 1'b0, 8'h00, 1'b0, 2'd1};
    tbl[3] = '{8'hBC, 1'b0, 8'h00, 1'b1, 2'd2};
    tbl[4] = '{8'h7C, 1'b0, 8'h00, 1'b1, 2'd2};
    tbl[5] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 2'd2};
    tbl[6] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 2'd2};
    tbl[7] = '{8'hBC, 1'b0, 8'h3C, 1'b1, 2'd2};
    for (int v = 0; v < 8; v++) begin
      send_byte(tbl[v].byte_in);
      check("tbl_valid",  32'(valid_out), 32'(tbl[v].exp_valid));
      check("tbl_data",   32'(data_out),  32'(tbl[v].exp_data));
      check("tbl_active", 32'(active),    32'(tbl[v].exp_active));
      check("tbl_state",  32'(state_out), 32'(tbl[v].exp_state));
    end

    // Gap loss: 32 IDLE bytes without COM, lock falls on the 32nd.
    for (int k = 1; k <= 32; k++) begin
      send_byte(IDL);
      if (k == 31) check("gap_active_31", 32'(active), 32'h1);
    end
    check("gap_active_32", 32'(active),    32'h0);
    check("gap_state_32",  32'(state_out), 32'h0);
    check("gap_data_held", 32'(data_out),  32'h3C);
    check("gap_valid",     32'(valid_out), 32'h0);

    // Misaligned start, abort on 8'h11, then relock.
    repeat (3) cycle(1'($urandom_range(0, 1)));
    send_byte(COM);
    send_byte(COM);
    check("abort_pre_state", 32'(state_out), 32'h1);
    send_byte(8'h11);
    check("abort_state", 32'(state_out), 32'h0);
    check("abort_valid", 32'(valid_out), 32'h0);
`ifdef SYNC_ERR_CNT_EN
    check("loss_cnt_two", 32'(lock_loss_cnt), 32'h2);
`endif
    repeat (3) send_byte(COM);
    check("relock_not_yet", 32'(active), 32'h0);
    send_byte(COM);
    check("relock_active", 32'(active),    32'h1);
    check("relock_state",  32'(state_out), 32'h2);

    // Async reset in the middle of a byte while locked.
    send_byte(8'hA5);
    check("pre_reset_data", 32'(data_out), 32'hA5);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_data",   32'(data_out),  32'h00);
    check("async_rst_valid",  32'(valid_out), 32'h0);
    check("async_rst_active", 32'(active),    32'h0);
    check("async_rst_state",  32'(state_out), 32'h0);
`ifdef SYNC_ERR_CNT_EN
    check("async_rst_loss", 32'(lock_loss_cnt), 32'h0);
`endif
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b0;
    send_byte(COM);
    check("one_com_active", 32'(active),    32'h0);
    check("one_com_state",  32'(state_out), 32'h1);
    send_byte(IDL);
    check("one_com_abort_state", 32'(state_out), 32'h0);
    check("one_com_abort_active", 32'(active), 32'h0);

    // Many aborted lock attempts drive the loss counter to saturation.
    for (int k = 0; k < 300; k++) begin
      send_byte(COM);
      send_byte(8'h11);
    end
    check("many_abort_state", 32'(state_out), 32'h0);
`ifdef SYNC_ERR_CNT_EN
    check("loss_cnt_sat", 32'(lock_loss_cnt), 32'hFF);
`endif

    // Randomized byte stream with occasional bit slips.
    reset = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    reset = 1'b0;
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        send_byte(COM);
      end else if (r < 65) begin
        send_byte(IDL);
      end else if (r < 93) begin
        send_byte(8'($urandom));
      end else begin
        int n;
        n = int'($urandom_range(1, 7));
        for (int j = 0; j < n; j++) cycle(1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
